// File: rtl/priority_encoder_reg.sv
// priority_encoder_reg: registered priority encoder with a valid/ready
// handshake on both sides. Each accepted request vector is encoded either
// with a fixed priority (highest index wins) or with a round-robin scan that
// starts just above the last granted index. The result is held in a one-deep
// output register that supports full back-to-back throughput.
module priority_encoder_reg #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_req,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    output logic [W-1:0] out_idx,
    output logic         out_zero,
    output logic         out_multi,
    output logic         out_valid,
    input  logic         out_ready
);

    // Result register and round-robin pointer.
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q,   out_idx_d;
    logic         out_zero_q,  out_zero_d;
    logic         out_multi_q, out_multi_d;
    logic [W-1:0] ptr_q,       ptr_d;

    // Encoder datapath.
    logic         accept;
    logic [N-1:0] req_m;
    logic [W-1:0] fixed_idx;
    logic [W-1:0] rr_idx;
    logic [W-1:0] rr_cand;
    logic         rr_found;
    logic         req_zero;
    logic         req_multi;

    // Handshake: the register can take a new vector when empty or draining.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        // Masking with in_valid keeps X on an idle bus out of the datapath.
        req_m    = in_valid ? in_req : '0;
    end

    // Zero / multiple-hit flags; clearing the lowest set bit leaves a
    // nonzero value exactly when two or more bits were set.
    always_comb begin
        req_zero  = (req_m == '0);
        req_multi = ((req_m & (req_m - N'(1))) != '0);
    end

    // Fixed priority: the last set bit found scanning upward is the highest.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        fixed_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req_m[i]) begin
                fixed_idx = W'(i);
            end
        end
    end

    // Round-robin: scan ptr+1, ptr+2, ... wrapping modulo N (N is a power of
    // two, so W-bit addition wraps for free); ptr itself is checked last.
    always_comb begin
        rr_idx   = '0;
        rr_cand  = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            rr_cand = ptr_q + W'(k);
            if (!rr_found && req_m[rr_cand]) begin
                rr_idx   = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    // Next-state: load on accept, clear on a consume without a refill,
    // otherwise hold. The pointer moves only on a nonzero round-robin grant.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_zero_d  = out_zero_q;
        out_multi_d = out_multi_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_idx_d   = mode ? rr_idx : fixed_idx;
            out_zero_d  = req_zero;
            out_multi_d = req_multi;
            if (mode && !req_zero) begin
                ptr_d = rr_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register; reset parks ptr at N-1 so the first scan starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_zero_q  <= 1'b0;
            out_multi_q <= 1'b0;
            ptr_q       <= W'(N - 1);
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_zero_q  <= out_zero_d;
            out_multi_q <= out_multi_d;
            ptr_q       <= ptr_d;
        end
    end

    // Output drive straight from the register.
    always_comb begin
        out_valid = out_valid_q;
        out_idx   = out_idx_q;
        out_zero  = out_zero_q;
        out_multi = out_multi_q;
    end

endmodule

// File: tb/tb_priority_encoder_reg.sv
// tb_priority_encoder_reg: scoreboard bench for priority_encoder_reg (N=8).
// Expected results come from a behavioural reference model and are queued
// at accept time, then popped when the result register updates.
module tb_priority_encoder_reg;

    localparam int N = 8;
    localparam int W = 3;

    typedef struct packed {
        logic [W-1:0] idx;
        logic         zero;
        logic         multi;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_req;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [W-1:0] out_idx;
    logic         out_zero;
    logic         out_multi;
    logic         out_valid;
    logic         out_ready;

    res_t         sb_q[$];
    int           vectors = 0;
    int           miscompares = 0;

    // Reference-model state.
    logic [W-1:0] m_ptr;
    logic         m_ov;
    res_t         m_held;

    priority_encoder_reg #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_idx   (out_idx),
        .out_zero  (out_zero),
        .out_multi (out_multi),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_encode(input logic [N-1:0] req, input logic md,
                                        input logic [W-1:0] p);
        res_t r;
        int   ones;
        r.idx   = '0;
        r.zero  = (req == '0);
        ones    = 0;
        for (int i = 0; i < N; i++) if (req[i]) ones++;
        r.multi = (ones >= 2);
        if (md) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (int'(p) + k) % N;
                if (req[c]) begin
                    r.idx = W'(c);
                    break;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    r.idx = W'(i);
                    break;
                end
            end
        end
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.idx   = out_idx;
        r.zero  = out_zero;
        r.multi = out_multi;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr  = W'(N - 1);
        m_ov   = 1'b0;
        m_held = '0;
        sb_q.delete();
    endtask

    // One clock of stimulus. Starts just after a rising edge, checks
    // in_ready before the edge and the result register after it.
    task automatic step(input string name, input logic v, input logic [N-1:0] req,
                        input logic md, input logic ordy);
        logic acc;
        res_t exp_r;
        res_t got;
        in_valid  = v;
        in_req    = req;
        mode      = md;
        out_ready = ordy;
        #1;
        vectors++;
        if (in_ready !== (!m_ov || ordy)) begin
            miscompares++;
            $display("FAIL %s in_ready: got %b, expected %b", name, in_ready, !m_ov || ordy);
        end
        acc = v && (!m_ov || ordy);
        if (acc) begin
            sb_q.push_back(ref_encode(req, md, m_ptr));
        end
        @(posedge clk);
        #1;
        if (acc) begin
            exp_r = sb_q.pop_front();
            if (md && req != '0) m_ptr = exp_r.idx;
            m_ov   = 1'b1;
            m_held = exp_r;
            got    = observed();
            vectors++;
            if (got !== exp_r) begin
                miscompares++;
                $display("FAIL %s result: got idx=%0d zero=%b multi=%b, expected idx=%0d zero=%b multi=%b",
                         name, got.idx, got.zero, got.multi, exp_r.idx, exp_r.zero, exp_r.multi);
            end
        end else if (m_ov) begin
            if (ordy) begin
                m_ov = 1'b0;
            end else begin
                got = observed();
                vectors++;
                if (got !== m_held) begin
                    miscompares++;
                    $display("FAIL %s hold: got idx=%0d zero=%b multi=%b, expected idx=%0d zero=%b multi=%b",
                             name, got.idx, got.zero, got.multi, m_held.idx, m_held.zero, m_held.multi);
                end
            end
        end
        vectors++;
        if (out_valid !== m_ov) begin
            miscompares++;
            $display("FAIL %s out_valid: got %b, expected %b", name, out_valid, m_ov);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if (out_valid !== 1'b0 || out_idx !== '0 || out_zero !== 1'b0 ||
            out_multi !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: got valid=%b idx=%0d zero=%b multi=%b ready=%b, expected 0 0 0 0 1",
                     name, out_valid, out_idx, out_zero, out_multi, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_req    = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("reset_initial");
        // A valid request across an edge during reset must not be accepted.
        in_valid = 1'b1;
        in_req   = 8'hFF;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_no_accept");
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_release");
    endtask

    task automatic test_fixed();
        step("fixed_single", 1'b1, 8'b0000_0001, 1'b0, 1'b1);
        step("fixed_ends",   1'b1, 8'b1000_0001, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) begin
            step("fixed_walk", 1'b1, N'(1) << i, 1'b0, 1'b1);
        end
        step("fixed_drain", 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            step("rr_b2b", 1'b1, 8'b1000_0001, 1'b1, 1'b1);
        end
        step("rr_drain", 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_zero_mode();
        logic [W-1:0] ptr_before;
        ptr_before = m_ptr;
        step("zero_rr", 1'b1, 8'h00, 1'b1, 1'b1);
        vectors++;
        if (m_ptr !== ptr_before || out_idx !== '0 || out_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_rr_ptr: got idx=%0d zero=%b, expected idx=0 zero=1",
                     out_idx, out_zero);
        end
        step("mode_fixed", 1'b1, 8'b0010_0100, 1'b0, 1'b1);
        step("mode_rr",    1'b1, 8'b0010_0100, 1'b1, 1'b1);
        step("mode_rr2",   1'b1, 8'b0010_0100, 1'b1, 1'b1);
        step("mode_rr3",   1'b1, 8'b0110_0110, 1'b1, 1'b1);
        step("mode_drain", 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        step("bp_load", 1'b1, 8'b0000_1100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("bp_hold", 1'b1, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end
        // X on an idle request bus must not disturb the held result.
        step("bp_idle_x", 1'b0, 'x, 1'b0, 1'b0);
        step("bp_release", 1'b1, 8'b0100_0000, 1'b0, 1'b1);
        step("bp_drain",   1'b0, '0, 1'b0, 1'b1);
        step("idle_x",     1'b0, 'x, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        step("mid_load", 1'b1, 8'b0011_1100, 1'b1, 1'b0);
        step("mid_hold", 1'b1, 8'b1111_0000, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("mid_reset_async");
        @(posedge clk);
        #1;
        check_reset_outputs("mid_reset_held");
        rst = 1'b0;
        step("mid_rr_all", 1'b1, 8'hFF, 1'b1, 1'b1);
        vectors++;
        if (out_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_rr_first: got idx=%0d, expected idx=0", out_idx);
        end
        step("mid_rr_next", 1'b1, 8'hFF, 1'b1, 1'b1);
        step("mid_drain",   1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_back_to_back();
        test_zero_mode();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
